nibble_serial_add_ctrl: RTL and testbench

//  Sequencer that adds two WIDTH-bit operands 4 bits per cycle through a single

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 14 +
 rtl/nibble_serial_add_ctrl_adder.sv | 21 ++
 rtl/nibble_serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package nibble_serial_add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/nibble_serial_add_ctrl_adder.sv
// 4-bit ripple-carry adder shared by every nibble pass of the controller.
module ripple_carry_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] carry;

    always_comb begin
        carry[0] = cin_i;
        for (int i = 0; i < 4; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[4];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit adder,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH-1:0]  res_sum_q, res_sum_d;
    logic              res_cout_q, res_cout_d, res_ovf_q, res_ovf_d;

    logic [IDXW+1:0]   base;
    logic [3:0]        nib_a, nib_b, nib_sum;
    logic              nib_cout;
    logic              last_nib;

    assign base     = {idx_q, 2'b00};
    assign nib_a    = a_q[base +: 4];
    assign nib_b    = b_q[base +: 4];
    assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

    ripple_carry_adder u_adder (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        res_ovf_d  = res_ovf_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[base +: 4] = nib_sum;
                carry_d          = nib_cout;
                if (last_nib) begin
                    // The final nibble's sum bit 3 is the result MSB.
                    res_sum_d  = sum_d;
                    res_cout_d = nib_cout;
                    res_ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
                    state_d    = StDone;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDone);
    assign out_sum   = res_sum_q;
    assign out_cout  = res_cout_q;
    assign out_ovf   = res_ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: 16-bit and 4-bit instances against a plain-arithmetic model.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_ovf, busy;
    logic [15:0] in_a, in_b, out_sum;

    logic        s_in_valid, s_in_ready, s_in_cin, s_out_valid, s_out_ready;
    logic        s_out_cout, s_out_ovf, s_busy;
    logic [3:0]  s_in_a, s_in_b, s_out_sum;

    int n_vec = 0;
    int n_err = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_a      (s_in_a),
        .in_b      (s_in_b),
        .in_cin    (s_in_cin),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_cout  (s_out_cout),
        .out_ovf   (s_out_ovf),
        .busy      (s_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                    output logic [15:0] s, output logic co, output logic ov);
        logic [16:0] t;
        t  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        s  = t[15:0];
        co = t[16];
        ov = (a[15] == b[15]) && (t[15] != a[15]);
    endfunction

    function automatic void model4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                   output logic [3:0] s, output logic co, output logic ov);
        logic [4:0] t;
        t  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        s  = t[3:0];
        co = t[4];
        ov = (a[3] == b[3]) && (t[3] != a[3]);
    endfunction

    // One 16-bit transaction; noise keeps in_valid high with junk operands while busy.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int hold, input bit noise, input string name);
        logic [15:0] es;
        logic        ec, eo;
        int          lat, waitc;
        model16(a, b, cin, es, ec, eo);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready_wait got=%b want=1", name, in_ready);
        end
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        lat = 0;
        in_valid = noise;
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            in_a = 16'($urandom); in_b = 16'($urandom);
        end
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || lat != 4) begin
            n_err++;
            $display("FAIL %s latency got=%0d valid=%b want=4", name, lat, out_valid);
        end
        n_vec++;
        if ({out_sum, out_cout, out_ovf} !== {es, ec, eo}) begin
            n_err++;
            $display("FAIL %s result got=%h/%b/%b want=%h/%b/%b", name, out_sum, out_cout,
                     out_ovf, es, ec, eo);
        end
        n_vec++;
        if ({in_ready, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL %s done_flags got in_ready=%b busy=%b want 0/1", name, in_ready, busy);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_vec++;
            if ({out_valid, in_ready, out_sum, out_cout, out_ovf} !== {2'b10, es, ec, eo}) begin
                n_err++;
                $display("FAIL %s hold%0d got v=%b r=%b %h/%b/%b want v=1 r=0 %h/%b/%b", name, i,
                         out_valid, in_ready, out_sum, out_cout, out_ovf, es, ec, eo);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready, busy, out_sum} !== {3'b010, es}) begin
            n_err++;
            $display("FAIL %s release got v=%b r=%b busy=%b sum=%h want 0/1/0 %h", name,
                     out_valid, in_ready, busy, out_sum, es);
        end
    endtask

    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                           input string name);
        logic [3:0] es;
        logic       ec, eo;
        int         lat;
        model4(a, b, cin, es, ec, eo);
        s_in_a = a; s_in_b = b; s_in_cin = cin; s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (s_out_valid !== 1'b1 || lat != 1) begin
            n_err++;
            $display("FAIL %s latency got=%0d valid=%b want=1", name, lat, s_out_valid);
        end
        n_vec++;
        if ({s_out_sum, s_out_cout, s_out_ovf} !== {es, ec, eo}) begin
            n_err++;
            $display("FAIL %s result got=%h/%b/%b want=%h/%b/%b", name, s_out_sum, s_out_cout,
                     s_out_ovf, es, ec, eo);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        n_vec++;
        if ({s_out_valid, s_in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL %s release got v=%b r=%b want 0/1", name, s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({in_ready, out_valid, busy, out_sum, out_cout, out_ovf} !== {3'b100, 16'h0, 2'b00}) begin
            n_err++;
            $display("FAIL reset16 got r=%b v=%b busy=%b %h/%b/%b want 1/0/0 0000/0/0", in_ready,
                     out_valid, busy, out_sum, out_cout, out_ovf);
        end
        n_vec++;
        if ({s_in_ready, s_out_valid, s_busy, s_out_sum, s_out_cout, s_out_ovf} !==
            {3'b100, 4'h0, 2'b00}) begin
            n_err++;
            $display("FAIL reset4 got r=%b v=%b busy=%b %h/%b/%b want 1/0/0 0/0/0", s_in_ready,
                     s_out_valid, s_busy, s_out_sum, s_out_cout, s_out_ovf);
        end
    endtask

    task automatic test_directed();
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "wrap");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, "ovf");
        run_op(16'h1234, 16'h4321, 1'b1, 1, 1'b0, "cin");
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0, "negovf");
    endtask

    task automatic test_backpressure();
        run_op(16'hA5C3, 16'h5A3C, 1'b1, 6, 1'b0, "backpressure");
    endtask

    task automatic test_ignore_during_run();
        run_op(16'h0F0F, 16'h00F1, 1'b0, 2, 1'b1, "ignore");
    endtask

    task automatic test_reset_mid_run();
        run_op(16'hBEEF, 16'h1111, 1'b1, 0, 1'b0, "pre_rst");
        in_a = 16'h4444; in_b = 16'h3333; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, out_valid, busy, out_sum, out_cout, out_ovf} !== {3'b100, 16'h0, 2'b00}) begin
            n_err++;
            $display("FAIL midrst got r=%b v=%b busy=%b %h/%b/%b want 1/0/0 0000/0/0", in_ready,
                     out_valid, busy, out_sum, out_cout, out_ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_hold%0d out_valid got=%b want=0", i, out_valid);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h4444, 16'h3333, 1'b0, 0, 1'b0, "post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), "random");
        end
    endtask

    task automatic test_width4();
        run_op4(4'hF, 4'hF, 1'b1, "w4_max");
        for (int i = 0; i < 8; i++) begin
            run_op4(4'($urandom), 4'($urandom), 1'($urandom), "w4_random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0; s_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_backpressure();
        test_ignore_during_run();
        test_reset_mid_run();
        test_random();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
